// File: rtl/divide_sequencer.sv
// Iterative radix-2 restoring divider for the execute stage: one quotient bit per clock,
// sign handled by magnitude pre-conversion and post-negation, start/busy/done handshake.
module divide_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_numer,
  input  logic [WIDTH-1:0] i_denom,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_divide_by_zero
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // RUN   | one restoring-division step per edge, WIDTH edges
  // FIX   | apply signs, publish results, pulse done
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic             w_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz_pend;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_numer_neg;
  logic             w_denom_neg;
  logic [WIDTH-1:0] w_numer_mag;
  logic [WIDTH-1:0] w_denom_mag;
  logic             w_denom_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;

  assign w_numer_neg  = i_is_signed & i_numer[WIDTH-1];
  assign w_denom_neg  = i_is_signed & i_denom[WIDTH-1];
  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
  assign w_numer_mag  = w_numer_neg ? -i_numer : i_numer;
  assign w_denom_mag  = w_denom_neg ? -i_denom : i_denom;
  assign w_denom_zero = (i_denom == '0);

  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, r_div};
  assign w_borrow = w_diff[WIDTH+1];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = w_denom_zero ? S_FIX : S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CW'(1)) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz_pend  <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i_abort) begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_cnt <= CW'(WIDTH);
              // a zero divisor preloads the final answer so FIX can publish it unchanged
              if (w_denom_zero) begin
                r_quo      <= '1;
                r_rem      <= i_numer;
                r_div      <= '0;
                r_neg_q    <= 1'b0;
                r_neg_r    <= 1'b0;
                r_dbz_pend <= 1'b1;
              end else begin
                r_quo      <= w_numer_mag;
                r_rem      <= '0;
                r_div      <= w_denom_mag;
                r_neg_q    <= w_numer_neg ^ w_denom_neg;
                r_neg_r    <= w_numer_neg;
                r_dbz_pend <= 1'b0;
              end
            end
          end
          S_RUN: begin
            r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
            r_cnt <= r_cnt - CW'(1);
          end
          S_FIX: begin
            r_quotient  <= r_neg_q ? -r_quo : r_quo;
            r_remainder <= r_neg_r ? -r_rem : r_rem;
            r_dbz       <= r_dbz_pend;
            r_done      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy           = w_busy;
  assign o_done           = r_done;
  assign o_quotient       = r_quotient;
  assign o_remainder      = r_remainder;
  assign o_divide_by_zero = r_dbz;

endmodule

// File: tb/tb_divide_sequencer.sv
// Directed bench for divide_sequencer (WIDTH=32): arithmetic, latency, divide-by-zero,
// overflow, abort, back-to-back handshake and asynchronous reset.
module tb_divide_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] numer = '0;
  logic [W-1:0] denom = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int total = 0;
  int bad = 0;

  divide_sequencer #(.WIDTH(W)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_start          (start),
    .i_is_signed      (is_signed),
    .i_numer          (numer),
    .i_denom          (denom),
    .i_abort          (abort),
    .o_busy           (busy),
    .o_done           (done),
    .o_quotient       (quotient),
    .o_remainder      (remainder),
    .o_divide_by_zero (dbz)
  );

  always #5 clk = ~clk;

  // Stimulus only: issues one divide, counts edges after E0 until done and busy cycles.
  task automatic run_div(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d,
                         output int edges, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; numer = n; denom = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cyc = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #23;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || dbz !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h dbz=%b exp all 0", busy, done, quotient, remainder, dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    int e, b;
    run_div(1'b0, 32'd100, 32'd7, e, b);
    total++;
    if (e !== 33) begin bad++; $display("FAIL unsigned_latency got=%0d exp=33", e); end
    total++;
    if (b !== 33) begin bad++; $display("FAIL unsigned_busy_cycles got=%0d exp=33", b); end
    total++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || dbz !== 1'b0) begin
      bad++; $display("FAIL unsigned_100_7 got q=%h r=%h dbz=%b exp q=0000000e r=00000002 dbz=0", quotient, remainder, dbz);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL done_with_busy got busy=%b exp=0", busy); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got done=%b exp=0", done); end
  endtask

  task automatic test_signed;
    int e, b;
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, e, b);
    total++;
    if (quotient !== 32'hFFFFFFF2 || remainder !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL signed_m100_7 got q=%h r=%h exp q=fffffff2 r=fffffffe", quotient, remainder);
    end
    run_div(1'b1, 32'd100, 32'hFFFFFFF9, e, b);
    total++;
    if (quotient !== 32'hFFFFFFF2 || remainder !== 32'd2) begin
      bad++; $display("FAIL signed_100_m7 got q=%h r=%h exp q=fffffff2 r=00000002", quotient, remainder);
    end
    run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, e, b);
    total++;
    if (quotient !== 32'd14 || remainder !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL signed_m100_m7 got q=%h r=%h exp q=0000000e r=fffffffe", quotient, remainder);
    end
  endtask

  task automatic test_div_by_zero;
    int e, b;
    run_div(1'b0, 32'h1234, 32'd0, e, b);
    total++;
    if (e !== 1 || b !== 1) begin bad++; $display("FAIL dbz_latency got edges=%0d busy=%0d exp 1 1", e, b); end
    total++;
    if (quotient !== 32'hFFFFFFFF || remainder !== 32'h1234 || dbz !== 1'b1) begin
      bad++; $display("FAIL dbz_result got q=%h r=%h dbz=%b exp q=ffffffff r=00001234 dbz=1", quotient, remainder, dbz);
    end
    run_div(1'b0, 32'd9, 32'd3, e, b);
    total++;
    if (quotient !== 32'd3 || remainder !== 32'd0 || dbz !== 1'b0) begin
      bad++; $display("FAIL after_dbz_9_3 got q=%h r=%h dbz=%b exp q=3 r=0 dbz=0", quotient, remainder, dbz);
    end
  endtask

  task automatic test_overflow;
    int e, b;
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, e, b);
    total++;
    if (quotient !== 32'd0 || remainder !== 32'h80000000 || dbz !== 1'b0) begin
      bad++; $display("FAIL unsigned_min_allones got q=%h r=%h dbz=%b exp q=0 r=80000000 dbz=0", quotient, remainder, dbz);
    end
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, e, b);
    total++;
    if (quotient !== 32'h80000000 || remainder !== 32'd0 || dbz !== 1'b0) begin
      bad++; $display("FAIL signed_overflow got q=%h r=%h dbz=%b exp q=80000000 r=0 dbz=0", quotient, remainder, dbz);
    end
    total++;
    if (e !== 33) begin bad++; $display("FAIL overflow_latency got=%0d exp=33", e); end
  endtask

  task automatic test_abort;
    int e, b;
    int seen;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; numer = 32'hFFFFFFFF; denom = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_done got pulses=%0d exp=0", seen); end
    total++;
    if (quotient !== 32'h80000000 || remainder !== 32'd0 || dbz !== 1'b0) begin
      bad++; $display("FAIL abort_results_held got q=%h r=%h dbz=%b exp q=80000000 r=0 dbz=0", quotient, remainder, dbz);
    end
    start = 1'b1; abort = 1'b1; numer = 32'd20; denom = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_beats_start got busy=%b exp=0", busy); end
    run_div(1'b0, 32'd20, 32'd6, e, b);
    total++;
    if (e !== 33 || quotient !== 32'd3 || remainder !== 32'd2) begin
      bad++; $display("FAIL restart_20_6 got edges=%0d q=%h r=%h exp 33 q=3 r=2", e, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int pulses, first, second, overlap;
    pulses = 0; first = -1; second = -1; overlap = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; numer = 32'd1000; denom = 32'd10;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 90; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done && busy) overlap++;
      if (done) begin
        pulses++;
        if (first < 0) first = k; else second = k;
      end
      if (k == 34) start = 1'b0;
    end
    total++;
    if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    total++;
    if (first !== 33 || second - first !== 34) begin
      bad++; $display("FAIL b2b_spacing got first=%0d gap=%0d exp first=33 gap=34", first, second - first);
    end
    total++;
    if (overlap !== 0) begin bad++; $display("FAIL b2b_done_busy_overlap got=%0d exp=0", overlap); end
    total++;
    if (quotient !== 32'd100 || remainder !== 32'd0) begin
      bad++; $display("FAIL b2b_result got q=%h r=%h exp q=00000064 r=0", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; numer = 32'd77; denom = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_run_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || dbz !== 1'b0) begin
      bad++; $display("FAIL async_reset got busy=%b done=%b q=%h r=%h dbz=%b exp all 0", busy, done, quotient, remainder, dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_by_zero;
    test_overflow;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
